// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage of the 5-stage MIPS pipeline.
//
// Owns the PC register and issues the synchronous instruction SRAM request.
// A branch/jump redirect that arrives while fetch is stalled is latched and
// applied on release, so it is never lost.
//
// Ports:
//   clk              clock, all state changes on posedge
//   rst              synchronous, active-high reset
//   stall            stall bus; only stall[0] (stop) is used, it holds the PC
//   br_bus           {br_e, br_addr[31:0]} from decode, valid the same cycle
//   if_to_id_bus     {ce, pc[31:0]} registered fetch state towards decode
//   inst_sram_en     fetch request enable
//   inst_sram_wen    write enables, always 0
//   inst_sram_addr   fetch address (the PC register)
//   inst_sram_wdata  write data, always 0
//   if_adel          fetch address misaligned while fetch is active
//   redirect_pending a redirect is latched but not yet applied
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter int unsigned STALL_W  = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic [32:0]        br_bus,
    output logic [32:0]        if_to_id_bus,
    output logic               inst_sram_en,
    output logic [3:0]         inst_sram_wen,
    output logic [31:0]        inst_sram_addr,
    output logic [31:0]        inst_sram_wdata,
    output logic               if_adel,
    output logic               redirect_pending
);

    logic        br_e;
    logic [31:0] br_addr;
    logic        stop;

    logic [31:0] pc_q, pc_d;
    logic        ce_q, ce_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_addr_q, pend_addr_d;
    logic [31:0] next_pc;

    // Only the stop bit matters to fetch; the rest of the bus is for later stages.
    logic unused_stall;
    assign unused_stall = ^stall;

    assign br_e    = br_bus[32];
    assign br_addr = br_bus[31:0];
    assign stop    = stall[0];

    // A live redirect beats a latched one; the latched one beats sequential fetch.
    always_comb begin
        if (br_e) begin
            next_pc = br_addr;
        end else if (pend_valid_q) begin
            next_pc = pend_addr_q;
        end else begin
            next_pc = pc_q + 32'd4;
        end
    end

    always_comb begin
        pc_d         = pc_q;
        ce_d         = ce_q;
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        if (!stop) begin
            pc_d         = next_pc;
            ce_d         = 1'b1;
            pend_valid_d = 1'b0;
        end else if (br_e) begin
            // Newest redirect wins if several arrive during one stall.
            pend_valid_d = 1'b1;
            pend_addr_d  = br_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // One word below the reset vector so the first advance lands on it.
            pc_q         <= RESET_PC - 32'd4;
            ce_q         <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= 32'd0;
        end else begin
            pc_q         <= pc_d;
            ce_q         <= ce_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
        end
    end

    assign if_to_id_bus     = {ce_q, pc_q};
    assign inst_sram_en     = ce_q & ~stop;
    assign inst_sram_wen    = 4'b0;
    assign inst_sram_addr   = pc_q;
    assign inst_sram_wdata  = 32'b0;
    assign if_adel          = ce_q & (pc_q[1:0] != 2'b00);
    assign redirect_pending = pend_valid_q;

endmodule
